// File: rtl/blink_seq_ctrl_if.sv
`timescale 1ns/1ps
// ---------------------------------------------------------------------------
// blink_seq_ctrl_if
//
// Purpose : Bundles the configuration/control inputs and the LED/status
//           outputs of blink_seq_ctrl so the register front end and the
//           sequencer connect through one port.
//
// Signals :
//   start_in        start request (front end -> sequencer)
//   stop_in         synchronous abort
//   on_ticks_in     ON duration in clock cycles      [TIMER_W]
//   off_ticks_in    OFF duration in clock cycles     [TIMER_W]
//   gap_ticks_in    inter-burst gap in clock cycles  [TIMER_W]
//   blink_count_in  blinks per burst                 [COUNT_W]
//   repeat_count_in bursts per run, 0 = continuous   [COUNT_W]
//   channel_mask_in channels allowed to light        [CHANNELS]
//   led_out         LED drive, active-high           [CHANNELS]
//   busy_out        high whenever the sequencer is not idle
//   done_out        one-cycle pulse at normal completion
//   state_out       current state encoding           [3]
//
// Modports:
//   master : front end side (drives start/stop/config, reads status)
//   slave  : sequencer side (reads start/stop/config, drives LEDs/status)
// ---------------------------------------------------------------------------
interface blink_seq_ctrl_if #(
  parameter int TIMER_W  = 16,
  parameter int COUNT_W  = 4,
  parameter int CHANNELS = 4
);

  logic                start_in;
  logic                stop_in;
  logic [TIMER_W-1:0]  on_ticks_in;
  logic [TIMER_W-1:0]  off_ticks_in;
  logic [TIMER_W-1:0]  gap_ticks_in;
  logic [COUNT_W-1:0]  blink_count_in;
  logic [COUNT_W-1:0]  repeat_count_in;
  logic [CHANNELS-1:0] channel_mask_in;
  logic [CHANNELS-1:0] led_out;
  logic                busy_out;
  logic                done_out;
  logic [2:0]          state_out;

  modport master (
    output start_in,
    output stop_in,
    output on_ticks_in,
    output off_ticks_in,
    output gap_ticks_in,
    output blink_count_in,
    output repeat_count_in,
    output channel_mask_in,
    input  led_out,
    input  busy_out,
    input  done_out,
    input  state_out
  );

  modport slave (
    input  start_in,
    input  stop_in,
    input  on_ticks_in,
    input  off_ticks_in,
    input  gap_ticks_in,
    input  blink_count_in,
    input  repeat_count_in,
    input  channel_mask_in,
    output led_out,
    output busy_out,
    output done_out,
    output state_out
  );

endinterface

// File: rtl/blink_seq_ctrl.sv
`timescale 1ns/1ps
// ---------------------------------------------------------------------------
// blink_seq_ctrl
//
// Purpose : Multi-channel LED blink sequencer. Runs bursts of N on/off blinks
//           separated by an idle gap, repeated M times (or forever when the
//           repeat count is 0), on a masked set of channels. Duration timer,
//           blink counter and repeat counter are all internal.
//
// Parameters:
//   TIMER_W   width of duration inputs and of the internal timer
//   COUNT_W   width of blink and repeat counts
//   CHANNELS  number of LED outputs (>= 2)
//
// Ports:
//   clock_in  system clock, rising edge
//   reset_in  asynchronous, active-high reset
//   bus       blink_seq_ctrl_if.slave: start/stop, durations, counts, mask
//             in; led_out, busy_out, done_out, state_out out
//
// Build option:
//   BLINK_SEQ_CHASE_EN  when defined, a one-hot pointer selects a single lit
//                       channel per blink (led = mask & pointer) and rotates
//                       left at each ON exit. When undefined, every masked
//                       channel lights together during ON.
//
// State encoding: IDLE=000 LOAD=001 ON=010 OFF=011 GAP=100 DONE=101.
// ---------------------------------------------------------------------------
module blink_seq_ctrl #(
  parameter int TIMER_W  = 16,
  parameter int COUNT_W  = 4,
  parameter int CHANNELS = 4
) (
  input  logic             clock_in,
  input  logic             reset_in,
  blink_seq_ctrl_if.slave  bus
);

  typedef enum logic [2:0] {
    ST_IDLE = 3'b000,
    ST_LOAD = 3'b001,
    ST_ON   = 3'b010,
    ST_OFF  = 3'b011,
    ST_GAP  = 3'b100,
    ST_DONE = 3'b101
  } state_t;

  state_t              state_q,       state_d;
  logic [TIMER_W-1:0]  timer_q,       timer_d;
  logic [COUNT_W-1:0]  blinksLeft_q,  blinksLeft_d;
  logic [COUNT_W-1:0]  repeatsLeft_q, repeatsLeft_d;

  // Configuration captured in LOAD; front-end changes mid-run are ignored.
  logic [TIMER_W-1:0]  onTicks_q,     onTicks_d;
  logic [TIMER_W-1:0]  offTicks_q,    offTicks_d;
  logic [TIMER_W-1:0]  gapTicks_q,    gapTicks_d;
  logic [COUNT_W-1:0]  blinkCount_q,  blinkCount_d;
  logic [COUNT_W-1:0]  repeatCount_q, repeatCount_d;
  logic [CHANNELS-1:0] mask_q,        mask_d;

  // Registered Moore outputs.
  logic [CHANNELS-1:0] led_q,         led_d;
  logic                busy_q,        busy_d;
  logic                done_q,        done_d;

`ifdef BLINK_SEQ_CHASE_EN
  logic [CHANNELS-1:0] ptr_q,         ptr_d;
`endif

  logic                infiniteRun;
  logic                abortReq;

  // Timer reload value for a phase: eff(x)-1 where eff(x) = max(x,1).
  function automatic logic [TIMER_W-1:0] durReload(input logic [TIMER_W-1:0] ticks);
    return (ticks == '0) ? '0 : (ticks - TIMER_W'(1));
  endfunction

  // Effective blink count, a zero request still produces one blink.
  function automatic logic [COUNT_W-1:0] effCount(input logic [COUNT_W-1:0] n);
    return (n == '0) ? COUNT_W'(1) : n;
  endfunction

  assign infiniteRun = (repeatCount_q == '0);

  // Stop only aborts an active run; DONE always finishes its pulse.
  assign abortReq = bus.stop_in &&
                    ((state_q == ST_LOAD) || (state_q == ST_ON) ||
                     (state_q == ST_OFF)  || (state_q == ST_GAP));

  // Next-state, timer, counter and capture logic.
  always_comb begin
    state_d       = state_q;
    timer_d       = timer_q;
    blinksLeft_d  = blinksLeft_q;
    repeatsLeft_d = repeatsLeft_q;
    onTicks_d     = onTicks_q;
    offTicks_d    = offTicks_q;
    gapTicks_d    = gapTicks_q;
    blinkCount_d  = blinkCount_q;
    repeatCount_d = repeatCount_q;
    mask_d        = mask_q;
`ifdef BLINK_SEQ_CHASE_EN
    ptr_d         = ptr_q;
`endif

    case (state_q)
      ST_IDLE: begin
        if (bus.start_in && !bus.stop_in) begin
          state_d = ST_LOAD;
        end
      end

      ST_LOAD: begin
        onTicks_d     = bus.on_ticks_in;
        offTicks_d    = bus.off_ticks_in;
        gapTicks_d    = bus.gap_ticks_in;
        blinkCount_d  = bus.blink_count_in;
        repeatCount_d = bus.repeat_count_in;
        mask_d        = bus.channel_mask_in;
        blinksLeft_d  = effCount(bus.blink_count_in);
        repeatsLeft_d = bus.repeat_count_in;
        timer_d       = durReload(bus.on_ticks_in);
`ifdef BLINK_SEQ_CHASE_EN
        ptr_d         = CHANNELS'(1);
`endif
        state_d       = ST_ON;
      end

      ST_ON: begin
        if (timer_q == '0) begin
`ifdef BLINK_SEQ_CHASE_EN
          ptr_d = {ptr_q[CHANNELS-2:0], ptr_q[CHANNELS-1]};
`endif
          if (blinksLeft_q <= COUNT_W'(1)) begin
            timer_d = durReload(gapTicks_q);
            state_d = ST_GAP;
          end else begin
            blinksLeft_d = blinksLeft_q - COUNT_W'(1);
            timer_d      = durReload(offTicks_q);
            state_d      = ST_OFF;
          end
        end else begin
          timer_d = timer_q - TIMER_W'(1);
        end
      end

      ST_OFF: begin
        if (timer_q == '0) begin
          timer_d = durReload(onTicks_q);
          state_d = ST_ON;
        end else begin
          timer_d = timer_q - TIMER_W'(1);
        end
      end

      ST_GAP: begin
        if (timer_q == '0) begin
          if (infiniteRun || (repeatsLeft_q > COUNT_W'(1))) begin
            if (!infiniteRun) begin
              repeatsLeft_d = repeatsLeft_q - COUNT_W'(1);
            end
            blinksLeft_d = effCount(blinkCount_q);
            timer_d      = durReload(onTicks_q);
            state_d      = ST_ON;
          end else begin
            state_d = ST_DONE;
          end
        end else begin
          timer_d = timer_q - TIMER_W'(1);
        end
      end

      ST_DONE: begin
        state_d = ST_IDLE;
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase

    if (abortReq) begin
      state_d = ST_IDLE;
    end
  end

  // Output decode from the next state so the registered outputs line up
  // with the registered state in the same cycle.
  always_comb begin
    led_d  = '0;
    busy_d = (state_d != ST_IDLE);
    done_d = (state_d == ST_DONE);
    if (state_d == ST_ON) begin
`ifdef BLINK_SEQ_CHASE_EN
      led_d = mask_d & ptr_d;
`else
      led_d = mask_d;
`endif
    end
  end

  // All sequencer state; reset drives everything dark and idle at once.
  always_ff @(posedge clock_in or posedge reset_in) begin
    if (reset_in) begin
      state_q       <= ST_IDLE;
      timer_q       <= '0;
      blinksLeft_q  <= '0;
      repeatsLeft_q <= '0;
      onTicks_q     <= '0;
      offTicks_q    <= '0;
      gapTicks_q    <= '0;
      blinkCount_q  <= '0;
      repeatCount_q <= '0;
      mask_q        <= '0;
      led_q         <= '0;
      busy_q        <= 1'b0;
      done_q        <= 1'b0;
`ifdef BLINK_SEQ_CHASE_EN
      ptr_q         <= CHANNELS'(1);
`endif
    end else begin
      state_q       <= state_d;
      timer_q       <= timer_d;
      blinksLeft_q  <= blinksLeft_d;
      repeatsLeft_q <= repeatsLeft_d;
      onTicks_q     <= onTicks_d;
      offTicks_q    <= offTicks_d;
      gapTicks_q    <= gapTicks_d;
      blinkCount_q  <= blinkCount_d;
      repeatCount_q <= repeatCount_d;
      mask_q        <= mask_d;
      led_q         <= led_d;
      busy_q        <= busy_d;
      done_q        <= done_d;
`ifdef BLINK_SEQ_CHASE_EN
      ptr_q         <= ptr_d;
`endif
    end
  end

  assign bus.led_out   = led_q;
  assign bus.busy_out  = busy_q;
  assign bus.done_out  = done_q;
  assign bus.state_out = state_q;

endmodule

// File: tb/tb_blink_seq_ctrl.sv
`timescale 1ns/1ps
// ---------------------------------------------------------------------------
// tb_blink_seq_ctrl
//
// Purpose : Self-checking bench for blink_seq_ctrl. Each started run pushes
//           its cycle-by-cycle expected trace (state, leds, busy, done) onto
//           a scoreboard queue, built directly from the phase lengths; every
//           negative clock edge pops one entry and compares it to the DUT.
//           Expected LEDs follow BLINK_SEQ_CHASE_EN when it is defined.
// ---------------------------------------------------------------------------
module tb_blink_seq_ctrl;

  localparam int TIMER_W  = 16;
  localparam int COUNT_W  = 4;
  localparam int CHANNELS = 4;

  localparam logic [2:0] S_IDLE = 3'b000;
  localparam logic [2:0] S_LOAD = 3'b001;
  localparam logic [2:0] S_ON   = 3'b010;
  localparam logic [2:0] S_OFF  = 3'b011;
  localparam logic [2:0] S_GAP  = 3'b100;
  localparam logic [2:0] S_DONE = 3'b101;

  typedef struct packed {
    logic [2:0]          st;
    logic [CHANNELS-1:0] led;
    logic                busy;
    logic                done;
  } exp_t;

  logic clock_in = 1'b0;
  logic reset_in = 1'b1;
  int   vectors     = 0;
  int   miscompares = 0;
  int   cycleNo     = 0;
  exp_t expQ[$];

  blink_seq_ctrl_if #(.TIMER_W(TIMER_W), .COUNT_W(COUNT_W), .CHANNELS(CHANNELS)) bus ();

  blink_seq_ctrl #(.TIMER_W(TIMER_W), .COUNT_W(COUNT_W), .CHANNELS(CHANNELS)) dut (
    .clock_in (clock_in),
    .reset_in (reset_in),
    .bus      (bus.slave)
  );

  always #5 clock_in = ~clock_in;

  // Hard time limit so a stuck run still ends with a report.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached at cycle %0d, expected completion", cycleNo);
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    vectors++;
    if (actual !== expected) begin
      miscompares++;
      $display("[TB] FAIL %s cycle %0d: got %0h expected %0h", tag, cycleNo, actual, expected);
    end
  endtask

  task automatic compareHead();
    exp_t e;
    e = expQ.pop_front();
    checkOutput("state", 32'(bus.state_out), 32'(e.st));
    checkOutput("led",   32'(bus.led_out),   32'(e.led));
    checkOutput("busy",  32'(bus.busy_out),  32'(e.busy));
    checkOutput("done",  32'(bus.done_out),  32'(e.done));
  endtask

  task automatic tick();
    @(negedge clock_in);
    cycleNo++;
    if (expQ.size() > 0) compareHead();
  endtask

  task automatic pushEntry(input logic [2:0] st, input logic [CHANNELS-1:0] led);
    exp_t e;
    e.st   = st;
    e.led  = led;
    e.busy = (st != S_IDLE);
    e.done = (st == S_DONE);
    expQ.push_back(e);
  endtask

  // Expected trace from LOAD through DONE (or maxBursts bursts if continuous).
  task automatic pushRun(input int onT, input int offT, input int gapT, input int blinkN,
                         input int repN, input logic [CHANNELS-1:0] mask, input int maxBursts);
    int effOn, effOff, effGap, effBlink, bursts;
    logic [CHANNELS-1:0] ptr;
    logic [CHANNELS-1:0] led;
    effOn    = (onT    == 0) ? 1 : onT;
    effOff   = (offT   == 0) ? 1 : offT;
    effGap   = (gapT   == 0) ? 1 : gapT;
    effBlink = (blinkN == 0) ? 1 : blinkN;
    bursts   = (repN   == 0) ? maxBursts : repN;
    ptr      = 1;
    pushEntry(S_LOAD, '0);
    for (int r = 0; r < bursts; r++) begin
      for (int b = 0; b < effBlink; b++) begin
`ifdef BLINK_SEQ_CHASE_EN
        led = mask & ptr;
`else
        led = mask;
`endif
        repeat (effOn) pushEntry(S_ON, led);
        ptr = {ptr[CHANNELS-2:0], ptr[CHANNELS-1]};
        if (b < effBlink - 1) repeat (effOff) pushEntry(S_OFF, '0);
      end
      repeat (effGap) pushEntry(S_GAP, '0);
    end
    if (repN != 0) pushEntry(S_DONE, '0);
  endtask

  // Drive a configuration with start raised and queue its expected trace.
  task automatic applyStimulus(input int onT, input int offT, input int gapT, input int blinkN,
                               input int repN, input logic [CHANNELS-1:0] mask, input int maxBursts);
    bus.on_ticks_in     = TIMER_W'(onT);
    bus.off_ticks_in    = TIMER_W'(offT);
    bus.gap_ticks_in    = TIMER_W'(gapT);
    bus.blink_count_in  = COUNT_W'(blinkN);
    bus.repeat_count_in = COUNT_W'(repN);
    bus.channel_mask_in = mask;
    bus.stop_in         = 1'b0;
    bus.start_in        = 1'b1;
    pushRun(onT, offT, gapT, blinkN, repN, mask, maxBursts);
  endtask

  // Step until the scoreboard drains; optional stop pulse, config scramble
  // after LOAD, and the cycle at which start is released.
  task automatic runSequence(input int stopAt, input bit scramble, input int dropStartAt);
    int cyc;
    cyc = 0;
    while (expQ.size() > 0) begin
      tick();
      cyc++;
      if (cyc == dropStartAt) bus.start_in = 1'b0;
      if (scramble && cyc == 2) begin
        bus.on_ticks_in     = TIMER_W'($urandom_range(0, 9));
        bus.off_ticks_in    = TIMER_W'($urandom_range(0, 9));
        bus.gap_ticks_in    = TIMER_W'($urandom_range(0, 9));
        bus.blink_count_in  = COUNT_W'($urandom_range(0, 15));
        bus.repeat_count_in = COUNT_W'($urandom_range(0, 15));
        bus.channel_mask_in = CHANNELS'($urandom_range(0, 15));
      end
      if (stopAt != 0) bus.stop_in = (cyc == stopAt);
    end
    bus.start_in = 1'b0;
    bus.stop_in  = 1'b0;
  endtask

  initial begin
    int stopAt;
    bus.start_in        = 1'b0;
    bus.stop_in         = 1'b0;
    bus.on_ticks_in     = '0;
    bus.off_ticks_in    = '0;
    bus.gap_ticks_in    = '0;
    bus.blink_count_in  = '0;
    bus.repeat_count_in = '0;
    bus.channel_mask_in = '0;

    // Reset values, during and after reset.
    #1;
    pushEntry(S_IDLE, '0);
    compareHead();
    repeat (2) @(negedge clock_in);
    reset_in = 1'b0;
    pushEntry(S_IDLE, '0);
    tick();

    $display("[TB] basic two-blink single burst");
    applyStimulus(3, 2, 4, 2, 1, 4'b0101, 1);
    pushEntry(S_IDLE, '0);
    runSequence(0, 1'b0, 1);

    $display("[TB] all-zero durations and count");
    applyStimulus(0, 0, 0, 0, 1, 4'b1111, 1);
    pushEntry(S_IDLE, '0);
    runSequence(0, 1'b0, 1);

    $display("[TB] two bursts, config changed mid-run");
    applyStimulus(1, 3, 2, 3, 2, 4'b1010, 1);
    pushEntry(S_IDLE, '0);
    runSequence(0, 1'b1, 1);

    $display("[TB] three bursts of one blink");
    applyStimulus(2, 0, 0, 0, 3, 4'b0110, 1);
    pushEntry(S_IDLE, '0);
    runSequence(0, 1'b0, 1);

    $display("[TB] continuous run aborted in GAP");
    applyStimulus(2, 5, 2, 1, 0, 4'b0011, 26);
    stopAt = expQ.size();
    pushEntry(S_IDLE, '0);
    pushEntry(S_IDLE, '0);
    runSequence(stopAt, 1'b1, 1);

    $display("[TB] start and stop together in IDLE");
    bus.start_in = 1'b1;
    bus.stop_in  = 1'b1;
    repeat (3) begin
      pushEntry(S_IDLE, '0);
      tick();
    end
    bus.start_in = 1'b0;
    bus.stop_in  = 1'b0;

    $display("[TB] start held through a whole run");
    applyStimulus(3, 2, 4, 2, 1, 4'b1100, 1);
    pushEntry(S_IDLE, '0);
    pushRun(3, 2, 4, 2, 1, 4'b1100, 1);
    pushEntry(S_IDLE, '0);
    runSequence(0, 1'b0, 16);

    $display("[TB] asynchronous reset mid-ON");
    applyStimulus(4, 1, 1, 1, 1, 4'b1111, 1);
    tick();
    bus.start_in = 1'b0;
    tick();
    tick();
    reset_in = 1'b1;
    #1;
    expQ.delete();
    pushEntry(S_IDLE, '0);
    compareHead();
    @(negedge clock_in);
    cycleNo++;
    reset_in = 1'b0;
    pushEntry(S_IDLE, '0);
    tick();
    applyStimulus(3, 2, 4, 2, 1, 4'b1001, 1);
    pushEntry(S_IDLE, '0);
    runSequence(0, 1'b0, 1);

    $display("[TB] five blinks, full and partial masks");
    applyStimulus(1, 1, 1, 5, 1, 4'b1111, 1);
    pushEntry(S_IDLE, '0);
    runSequence(0, 1'b0, 1);
    applyStimulus(2, 1, 1, 5, 1, 4'b1011, 1);
    pushEntry(S_IDLE, '0);
    runSequence(0, 1'b0, 1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
